strobe_write_queue: RTL and testbench
=====================================

# strobe_write_queue

- Write-side companion to the falling-edge strobe used by the register file and data memory.
- Accepts pipeline write requests on the rising edge of `clk` and buffers them in an in-order queue.
- Commits one entry to the storage array per cycle in which the edge strobe is sampled high, so array writes land in the inverted-phase window.
- Sits between the WB/MEM stage and the register file or data memory write port.

## Interface
Parameters:
- ADDR_W, 5, storage address width
- DATA_W, 32, write data width
- DEPTH, 4, queue entries; power of two, ≥ 2

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  write request present
- wr_ready  out  1  queue can accept; `count != DEPTH`
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- strobe  in  1  edge strobe from the falling-edge detector, sampled as a level on the rising edge
- mem_we  out  1  registered write enable to the storage array
- mem_addr  out  ADDR_W  registered commit address
- mem_wdata  out  DATA_W  registered commit data
- rd_addr  in  ADDR_W  read address for bypass lookup
- rd_hit  out  1  combinational; a queued entry matches `rd_addr`
- rd_data  out  DATA_W  combinational; data of the newest matching entry
- count  out  $clog2(DEPTH)+1  occupancy, including any entry being committed

## Operation
- Queue behaviour:
  - Circular buffer with head and tail pointers of $clog2(DEPTH) bits each; pointers wrap modulo DEPTH.
  - Push when `wr_valid & wr_ready`.
  - A push and a pop in the same cycle leave `count` unchanged.
  - A push while full is never accepted, because `wr_ready` = 0.
- Drain FSM:
  - IDLE: `count` = 0. Go to WAIT when a push occurs.
  - WAIT: `count` ≥ 1. On a sampled `strobe` = 1, go to COMMIT and register the head entry onto `mem_addr`/`mem_wdata`, with `mem_we` = 1.
  - COMMIT: `mem_we` = 1 for exactly this cycle; the head is popped at the end of the cycle.
    - If `strobe` = 1 and entries remain after the pop (counting a same-cycle push), stay in COMMIT with the next head.
    - Otherwise, if entries remain, go to WAIT.
    - Otherwise go to IDLE.
- `strobe` is ignored in IDLE.
- All addresses, including 0, are committed unmodified; any address-0 policy belongs to the array.
- Entries commit strictly in push order; none are dropped or merged.
- `mem_addr`/`mem_wdata` hold their last values while `mem_we` = 0.

## Timing
- Reset values: state IDLE, pointers 0, `count` 0, `wr_ready` 1, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `rd_hit` 0, `rd_data` 0.
- Reset is asynchronous; asserting it mid-commit drops `mem_we` immediately and flushes all queued entries.
- Latency:
  - Push at edge N, `strobe` high at edge N+1: `mem_we` is high in cycle N+1..N+2.
  - Minimum push-to-commit latency is 1 cycle.
- Throughput: one commit per cycle while `strobe` is held high and the queue is non-empty.
- `wr_ready` is derived from registered `count` only; it never depends on `wr_valid` or `strobe` in the same cycle.
- Full and committing: `wr_ready` = 0 for that cycle even though a pop occurs; a slot opens on the next cycle.
- `count` decrements at the end of the COMMIT cycle.

## Configuration
- Macro: `STROBE_WQ_BYPASS_EN`.
- When defined:
  - `rd_hit`/`rd_data` search all occupied entries, including the one in COMMIT.
  - The newest matching entry wins.
  - A same-cycle incoming push is not visible.
- When undefined: `rd_hit` and `rd_data` are tied to 0 and no comparators are built.

## Test plan
- Reset, then push addr 3/data 0xDEADBEEF, `strobe` low for 5 cycles, then high for 1 cycle -> `mem_we` high exactly 1 cycle with addr 3/0xDEADBEEF; `count` goes 1 -> 0.
- DEPTH = 4: push 5 writes back-to-back with `strobe` low -> `wr_ready` drops after the 4th; the 5th is held; `count` = 4.
- Fill 4 entries (addr 1..4), hold `strobe` high -> 4 consecutive `mem_we` cycles in order 1, 2, 3, 4; state returns to IDLE.
- Push and commit in the same cycle at `count` = 2 -> `count` stays 2; FIFO order is preserved.
- Assert `rst` during a COMMIT cycle with 3 entries queued -> `mem_we` falls without waiting for an edge; `count` = 0; no later commits occur.
- With `STROBE_WQ_BYPASS_EN`: queue addr 7/0x11 then addr 7/0x22, `rd_addr` = 7 -> `rd_hit` = 1, `rd_data` = 0x22. Without the macro -> `rd_hit` = 0.

Source files
------------

// File: rtl/strobe_write_queue.sv
// In-order write queue that commits one entry per sampled edge strobe to a storage write port.
// Optional read bypass over queued entries is enabled by defining STROBE_WQ_BYPASS_EN.
module strobe_write_queue #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   strobe,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic                   rd_hit,
    output logic [DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StWait, StCommit} state_e;

    state_e            state_q;
    logic [PtrW-1:0]   head_q, tail_q, head_nxt;
    logic [CntW-1:0]   count_q, count_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              push, pop;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_data;

    assign wr_ready = (count_q != CntW'(DEPTH));

    always_comb begin
        push     = wr_valid && wr_ready;
        pop      = (state_q == StCommit);
        count_d  = count_q + CntW'(push) - CntW'(pop);
        head_nxt = head_q + PtrW'(1);
        // With only the committing entry queued, the follow-on head is the same-cycle push.
        if (count_q == CntW'(1)) begin
            nxt_addr = wr_addr;
            nxt_data = wr_data;
        end else begin
            nxt_addr = addr_q[head_nxt];
            nxt_data = data_q[head_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= wr_addr;
            data_q[tail_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) tail_q <= tail_q + PtrW'(1);
            if (pop)  head_q <= head_nxt;
            unique case (state_q)
                StIdle: begin
                    mem_we_q <= 1'b0;
                    if (push) state_q <= StWait;
                end
                StWait: begin
                    if (strobe) begin
                        state_q     <= StCommit;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q[head_q];
                        mem_wdata_q <= data_q[head_q];
                    end else begin
                        mem_we_q <= 1'b0;
                    end
                end
                StCommit: begin
                    if (strobe && count_d != '0) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= nxt_addr;
                        mem_wdata_q <= nxt_data;
                    end else begin
                        mem_we_q <= 1'b0;
                        state_q  <= (count_d != '0) ? StWait : StIdle;
                    end
                end
                default: begin
                    mem_we_q <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;

`ifdef STROBE_WQ_BYPASS_EN
    logic [PtrW-1:0] idx;

    // Walk oldest to newest so the newest match is the one left standing.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        idx     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PtrW'(i);
            if ((CntW'(i) < count_q) && (addr_q[idx] == rd_addr)) begin
                rd_hit  = 1'b1;
                rd_data = data_q[idx];
            end
        end
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_hit         = 1'b0;
    assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_strobe_write_queue.sv
// Scoreboard bench for strobe_write_queue: expected commits are queued at push time and
// checked by an independent monitor whenever mem_we is seen.
module tb_strobe_write_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        strobe = 1'b0;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [4:0]  rd_addr = '0;
    logic        rd_hit;
    logic [31:0] rd_data;
    logic [2:0]  count;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   commits  = 0;
    int   snap;

    strobe_write_queue #(.ADDR_W(5), .DATA_W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .strobe    (strobe),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .rd_addr   (rd_addr),
        .rd_hit    (rd_hit),
        .rd_data   (rd_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
        ent_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        strobe = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (count == 3'd0 && !mem_we) break;
        end
        chk("drain_count", 64'(count), 64'd0);
        strobe = 1'b0;
    endtask

    // Monitor: every commit must match the oldest outstanding expected entry.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            commits++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_commit actual=%0h/%0h required=none", mem_addr,
                         mem_wdata);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("commit_addr", 64'(mem_addr), 64'(e.a));
                chk("commit_data", 64'(mem_wdata), 64'(e.d));
            end
        end
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_rd_hit", 64'(rd_hit), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Single write, strobe low 5 cycles then high for 1.
        wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        push_exp(5'd3, 32'hDEADBEEF);
        tick();
        wr_valid = 1'b0;
        chk("t1_count_after_push", 64'(count), 64'd1);
        repeat (5) tick();
        chk("t1_no_early_commit", 64'(count), 64'd1);
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        chk("t1_we_high", 64'(mem_we), 64'd1);
        chk("t1_count_in_commit", 64'(count), 64'd1);
        tick();
        chk("t1_we_low", 64'(mem_we), 64'd0);
        chk("t1_count_end", 64'(count), 64'd0);
        chk("t1_addr_hold", 64'(mem_addr), 64'd3);

        // Five back-to-back pushes into a 4-deep queue, strobe low.
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(10 + i); wr_data = 32'h100 + 32'(i);
            chk("t2_wr_ready", 64'(wr_ready), (i < 4) ? 64'd1 : 64'd0);
            if (i < 4) push_exp(5'(10 + i), 32'h100 + 32'(i));
            tick();
        end
        chk("t2_count_full", 64'(count), 64'd4);
        chk("t2_ready_full", 64'(wr_ready), 64'd0);
        strobe = 1'b1;
        tick();
        chk("t2_full_commit_we", 64'(mem_we), 64'd1);
        chk("t2_full_commit_ready", 64'(wr_ready), 64'd0);
        tick();
        chk("t2_slot_open", 64'(wr_ready), 64'd1);
        chk("t2_count_after_pop", 64'(count), 64'd3);
        push_exp(5'd14, 32'h104);
        tick();
        wr_valid = 1'b0;
        chk("t2_push_pop_count", 64'(count), 64'd3);
        drain();

        // Fill 1..4 then hold strobe: four consecutive commits.
        for (int i = 1; i <= 4; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(i); wr_data = 32'hA0 + 32'(i);
            push_exp(5'(i), 32'hA0 + 32'(i));
            tick();
        end
        wr_valid = 1'b0;
        strobe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_burst_we", 64'(mem_we), 64'd1);
        end
        tick();
        strobe = 1'b0;
        chk("t3_burst_end_we", 64'(mem_we), 64'd0);
        chk("t3_burst_end_count", 64'(count), 64'd0);

        // Push and commit in the same cycle at count 2.
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(20 + i); wr_data = 32'hB0 + 32'(i);
            push_exp(5'(20 + i), 32'hB0 + 32'(i));
            tick();
        end
        wr_valid = 1'b0;
        strobe = 1'b1;
        tick();
        chk("t4_count_pre", 64'(count), 64'd2);
        strobe = 1'b0;
        wr_valid = 1'b1; wr_addr = 5'd22; wr_data = 32'hB2;
        push_exp(5'd22, 32'hB2);
        tick();
        wr_valid = 1'b0;
        chk("t4_count_same", 64'(count), 64'd2);
        drain();

        // Single entry committing while a push arrives with strobe still high.
        wr_valid = 1'b1; wr_addr = 5'd30; wr_data = 32'hC0;
        push_exp(5'd30, 32'hC0);
        tick();
        wr_valid = 1'b0;
        strobe = 1'b1;
        tick();
        wr_valid = 1'b1; wr_addr = 5'd31; wr_data = 32'hC1;
        push_exp(5'd31, 32'hC1);
        tick();
        wr_valid = 1'b0;
        strobe = 1'b0;
        chk("t4b_back_to_back_we", 64'(mem_we), 64'd1);
        chk("t4b_next_addr", 64'(mem_addr), 64'd31);
        chk("t4b_count", 64'(count), 64'd1);
        tick();
        chk("t4b_count_end", 64'(count), 64'd0);

        // Reset during a commit with 3 entries queued.
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(40 + i); wr_data = 32'hD0 + 32'(i);
            push_exp(5'(40 + i), 32'hD0 + 32'(i));
            tick();
        end
        wr_valid = 1'b0;
        strobe = 1'b1;
        tick();
        chk("t5_we_before_rst", 64'(mem_we), 64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_we_async_drop", 64'(mem_we), 64'd0);
        chk("t5_count_flushed", 64'(count), 64'd0);
        exp_q.delete();
        snap = commits;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        strobe = 1'b0;
        chk("t5_no_later_commits", 64'(commits), 64'(snap));
        chk("t5_count_after", 64'(count), 64'd0);

        // Bypass lookup: newest matching entry wins.
        wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
        push_exp(5'd7, 32'h11);
        tick();
        wr_data = 32'h22;
        push_exp(5'd7, 32'h22);
        tick();
        wr_valid = 1'b0;
        rd_addr = 5'd7;
        #1;
`ifdef STROBE_WQ_BYPASS_EN
        chk("t6_rd_hit", 64'(rd_hit), 64'd1);
        chk("t6_rd_data", 64'(rd_data), 64'h22);
`else
        chk("t6_rd_hit", 64'(rd_hit), 64'd0);
        chk("t6_rd_data", 64'(rd_data), 64'd0);
`endif
        rd_addr = 5'd8;
        #1;
        chk("t6_rd_miss", 64'(rd_hit), 64'd0);
        drain();
        wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'h33;
        push_exp(5'd9, 32'h33);
        tick();
        wr_valid = 1'b0;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        rd_addr = 5'd9;
        #1;
`ifdef STROBE_WQ_BYPASS_EN
        chk("t6_rd_hit_commit", 64'(rd_hit), 64'd1);
        chk("t6_rd_data_commit", 64'(rd_data), 64'h33);
`else
        chk("t6_rd_hit_commit", 64'(rd_hit), 64'd0);
`endif
        tick();
        chk("t6_rd_after_drain", 64'(rd_hit), 64'd0);

        tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
